// File: rtl/serdes_chan_pkg.sv
// Shared definitions for the SERDES loopback channel model and its LFSR noise source.
package serdes_chan_pkg;

  localparam int          BLK_W     = 66;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [1:0] SYNC_BAD  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  function automatic logic [6:0] next_offset(input logic [6:0] off);
    return (off == 7'd65) ? 7'd0 : off + 7'd1;
  endfunction

endpackage

// File: rtl/serdes_chan_model_lfsr.sv
// 32-bit Galois LFSR, free running from reset; shared with other noise benches.
module lfsr_galois32
  import serdes_chan_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Shift right and fold the tap mask back in when a one falls out.
  always_comb begin
    state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0000_0000);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/serdes_chan_model.sv
// Loopback channel between TX and RX SERDES: bitslip gearbox emulation,
// programmable header/data error injection and saturating BER counters.
module serdes_chan_model
  import serdes_chan_pkg::*;
#(
  parameter int          DATA_WIDTH  = 64,
  parameter int          HDR_WIDTH   = 2,
  parameter int          INIT_OFFSET = 0,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  bitslip,
  input  logic                  reset_req,
  input  logic [31:0]           cfg_threshold,
  input  logic                  cfg_hdr_err_en,
  input  logic                  cfg_data_err_en,
  input  logic [7:0]            cfg_burst_len,
  input  logic                  cfg_force_err,
  input  logic                  cnt_clear,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic [6:0]            offset,
  output logic [CNT_WIDTH-1:0]  blk_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [6:0]            INIT_OFF = 7'(INIT_OFFSET);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [BLK_W-1:0]      blk_s, win_s;
  logic [2*BLK_W-1:0]    cat_s;
  logic [BLK_W-1:0]      hist_q, hist_d;
  logic [6:0]            offset_q, offset_d;
  logic                  bitslip_q;
  logic                  slip_s;
  logic [31:0]           lfsr_s;
  burst_state_e          state_q, state_d;
  logic [7:0]            rem_q, rem_d;
  logic [7:0]            burst_eff_s;
  logic                  trig_s, err_blk_s, err_cnt_s;
  logic [DATA_WIDTH-1:0] flip_s;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [HDR_WIDTH-1:0]  out_hdr_q, out_hdr_d;
  logic [CNT_WIDTH-1:0]  blk_cnt_q, blk_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt, input logic en);
    return (en && (cnt != CNT_MAX)) ? cnt + CNT_ONE : cnt;
  endfunction

  lfsr_galois32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (lfsr_s)
  );

  // Header is the first bit on the wire, so it sits in the LSBs of each block.
  assign blk_s       = {in_data, in_hdr};
  assign cat_s       = {blk_s, hist_q};
  assign win_s       = cat_s[offset_q +: BLK_W];
  assign slip_s      = bitslip & ~bitslip_q;
  assign trig_s      = (lfsr_s < cfg_threshold) | cfg_force_err;
  assign burst_eff_s = (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
  assign flip_s      = (err_blk_s & cfg_data_err_en) ? (DATA_ONE << lfsr_s[5:0]) : {DATA_WIDTH{1'b0}};
  assign err_cnt_s   = err_blk_s & (cfg_hdr_err_en | cfg_data_err_en) & ~reset_req;

  // Burst FSM: the triggering block is errored, then rem more follow.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    err_blk_s = 1'b0;
    if (reset_req) begin
      state_d = IDLE;
      rem_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_s) begin
            err_blk_s = 1'b1;
            rem_d     = burst_eff_s - 8'd1;
            state_d   = (burst_eff_s == 8'd1) ? IDLE : BURST;
          end else begin
            state_d = IDLE;
          end
        end
        BURST: begin
          err_blk_s = 1'b1;
          rem_d     = rem_q - 8'd1;
          state_d   = (rem_q == 8'd1) ? IDLE : BURST;
        end
        default: begin
          state_d = IDLE;
          rem_d   = 8'd0;
        end
      endcase
    end
  end

  // Window, offset and output next-state; reset_req clears the datapath and drops any slip.
  always_comb begin
    hist_d     = hist_q;
    offset_d   = offset_q;
    out_data_d = out_data_q;
    out_hdr_d  = out_hdr_q;
    if (reset_req) begin
      hist_d     = {BLK_W{1'b0}};
      offset_d   = INIT_OFF;
      out_data_d = {DATA_WIDTH{1'b0}};
      out_hdr_d  = {HDR_WIDTH{1'b0}};
    end else begin
      hist_d     = blk_s;
      offset_d   = slip_s ? next_offset(offset_q) : offset_q;
      out_data_d = win_s[BLK_W-1:HDR_WIDTH] ^ flip_s;
      out_hdr_d  = (err_blk_s & cfg_hdr_err_en) ? SYNC_BAD : win_s[HDR_WIDTH-1:0];
    end
  end

  // Saturating counters; clear beats increment.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clear) begin
      blk_cnt_d = {CNT_WIDTH{1'b0}};
      err_cnt_d = {CNT_WIDTH{1'b0}};
    end else begin
      blk_cnt_d = sat_inc(blk_cnt_q, ~reset_req);
      err_cnt_d = sat_inc(err_cnt_q, err_cnt_s);
    end
  end

  // All channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= {BLK_W{1'b0}};
      offset_q   <= INIT_OFF;
      bitslip_q  <= 1'b0;
      state_q    <= IDLE;
      rem_q      <= 8'd0;
      out_data_q <= {DATA_WIDTH{1'b0}};
      out_hdr_q  <= {HDR_WIDTH{1'b0}};
      blk_cnt_q  <= {CNT_WIDTH{1'b0}};
      err_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      hist_q     <= hist_d;
      offset_q   <= offset_d;
      bitslip_q  <= bitslip;
      state_q    <= state_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_hdr_q  <= out_hdr_d;
      blk_cnt_q  <= blk_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_hdr   = out_hdr_q;
  assign offset    = offset_q;
  assign blk_count = blk_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/serdes_chan_model.md
# serdes_chan_model

Synthesizable SERDES channel model between `eth_phy_10g` TX SERDES outputs and RX SERDES inputs for loopback testing. Emulates a receive gearbox that honours `serdes_rx_bitslip` by shifting the 66-bit block boundary one bit per request. Injects header and data errors at a programmable rate and burst length. Keeps saturating block and error counters for BER measurement.

## Interface
- `DATA_WIDTH`, 64: data bits per block; only 64 supported.
- `HDR_WIDTH`, 2: sync header bits; only 2 supported.
- `INIT_OFFSET`, 0: boundary offset after reset/reset_req, 0..65.
- `LFSR_SEED`, 32'hACE12468: LFSR reset value; must be nonzero.
- `CNT_WIDTH`, 32: counter width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 64: block data from `serdes_tx_data`.
- `in_hdr` in 2: header from `serdes_tx_hdr`.
- `bitslip` in 1: from `serdes_rx_bitslip`; rising edge = one slip.
- `reset_req` in 1: from `serdes_rx_reset_req`; level-sensitive.
- `cfg_threshold` in 32: error trigger when `lfsr < cfg_threshold`; 0 = never.
- `cfg_hdr_err_en` in 1: errored blocks get header forced to 2'b11.
- `cfg_data_err_en` in 1: errored blocks get data bit `lfsr[5:0]` inverted.
- `cfg_burst_len` in 8: blocks per error event; 0 treated as 1.
- `cfg_force_err` in 1: single-cycle pulse forces one error event.
- `cnt_clear` in 1: synchronous clear of both counters.
- `out_data` out 64: to `serdes_rx_data`.
- `out_hdr` out 2: to `serdes_rx_hdr`.
- `offset` out 7: current boundary offset, 0..65.
- `blk_count` out CNT_WIDTH: blocks output since clear, saturating.
- `err_count` out CNT_WIDTH: errored blocks since clear, saturating.

## Operation
- Block packing: `blk = {in_data, in_hdr}`, 66 bits, header in the LSBs (sent first). `hist` register holds the previous `blk`.
- Window: `win = {blk, hist}[offset +: 66]`, 132-bit concat. Offset 0 passes `hist` through unchanged.
- Bitslip: `bitslip` is registered. On `bitslip & ~bitslip_q`, `offset <= (offset==65) ? 0 : offset+1`. A level held high gives exactly one slip.
- reset_req: while high, `offset <= INIT_OFFSET`, `hist <= 0`, `out_data/out_hdr <= 0`, burst FSM to IDLE. Counters and LFSR keep running.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every cycle out of reset. The compare and data bit index use the pre-advance value.
- Burst FSM:
  - IDLE: on trigger (`lfsr < cfg_threshold` or `cfg_force_err`), the current block is errored. Go to BURST with `rem = max(cfg_burst_len,1) - 1`; if `rem == 0`, stay in IDLE.
  - BURST: current block is errored. Decrement `rem`; return to IDLE when it reaches 0. Triggers during BURST are ignored.
- Error application, on the output register:
  - Header becomes 2'b11 if `cfg_hdr_err_en`.
  - `out_data[lfsr[5:0]]` is inverted if `cfg_data_err_en`.
  - A block with both enables off is not counted as errored.
- Counters:
  - `blk_count` increments every non-reset_req cycle.
  - `err_count` increments on each counted errored block.
  - Both saturate at all-ones. `cnt_clear` has priority over increment.
- Reset values: `out_data` 0, `out_hdr` 2'b00, `offset` INIT_OFFSET, `hist` 0, `lfsr` LFSR_SEED, counters 0, FSM IDLE, `bitslip_q` 0.

## Timing
- Latency at offset 0: `in_*` at cycle N appears on `out_*` after the edge of cycle N+2 (`hist` register plus output register).
- An offset change takes effect on the window one cycle after the bitslip edge is detected.
- Simultaneous bitslip edge and reset_req: reset_req wins and the slip is dropped.
- `cfg_*` are sampled each cycle. Changing them mid-burst does not alter `rem`.
- Counters update in the same edge as the output register.

## Structure
- Shared package `serdes_chan_pkg`:
  - constant `BLK_W` = 66
  - LFSR polynomial tap mask
  - FSM state enum IDLE/BURST
  - `SYNC_DATA` = 2'b01, `SYNC_CTRL` = 2'b10, `SYNC_BAD` = 2'b11
- Sub-module `lfsr_galois32`: clk, rst_n, seed param, state out. Reused by other noise benches.
- Top level contains the window mux, bitslip edge detect, burst FSM, error application and counters.

## Test plan
- Reset and pass-through: threshold 0, offset 0, input sequence 64'h5555…/2'b10 then 64'hAAAA…/2'b01 → identical blocks out 2 cycles later, err_count 0.
- Bitslip: `bitslip` held high for 3 cycles → offset 0→1 only, and output equals the 1-bit-shifted concat. After 66 pulses offset wraps to 0 → pass-through again.
- Lock hunt: INIT_OFFSET=17 looped to `eth_phy_10g` with PRBS31 → PHY slips until `rx_block_lock`=1 and offset equals 0 mod 66.
- Forced burst: burst_len 4, hdr_en=1, one `cfg_force_err` pulse → exactly 4 consecutive out_hdr 2'b11 and err_count=4. A second force during the burst has no effect.
- Rate: threshold 32'h028F5C29 (≈1%) for 100000 blocks → err_count within 1000±150, blk_count 100000. With `cnt_clear` → both 0 next cycle.
- reset_req mid-burst: output goes 0, FSM returns to IDLE, offset returns to INIT_OFFSET. Saturation: with CNT_WIDTH=4 and threshold all-ones, err_count holds at 15.
